// File: rtl/imem_port_arbiter.sv
// Sequencer and two-way arbiter for a byte-wide, single-port instruction memory.
// Fetches assemble a 32-bit little-endian word from four byte beats; the loader writes single bytes.
module imem_port_arbiter #(
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst_n,
  input  logic                  i_Fetch_Req,
  input  logic [31:0]           i_Fetch_Addr,
  output logic                  o_Fetch_Ack,
  output logic [31:0]           o_Instruction,
  output logic                  o_Fetch_Err,
  input  logic                  i_Load_Req,
  input  logic [31:0]           i_Load_Addr,
  input  logic [7:0]            i_Load_Data,
  output logic                  o_Load_Ack,
  output logic [ADDR_WIDTH-1:0] o_Mem_Addr,
  output logic [7:0]            o_Mem_Wdata,
  output logic                  o_Mem_We,
  input  logic [7:0]            i_Mem_Rdata
);

  typedef enum logic [1:0] {StIdle, StFetch, StLoad} state_e;

  state_e      state_q;
  logic [2:0]  cnt_q;
  logic [23:0] shift_q;
  logic        last_load_q;

  logic fetch_pend, load_pend, grant_fetch, grant_load, fetch_legal, load_in_range;

  // A request seen during its own ack cycle is the one just served, not a new one.
  always_comb begin
    fetch_pend    = i_Fetch_Req & ~o_Fetch_Ack;
    load_pend     = i_Load_Req & ~o_Load_Ack;
    grant_fetch   = fetch_pend & (~load_pend | last_load_q);
    grant_load    = load_pend & ~grant_fetch;
    fetch_legal   = (i_Fetch_Addr[1:0] == 2'b00) && ((i_Fetch_Addr >> ADDR_WIDTH) == 32'd0);
    load_in_range = ((i_Load_Addr >> ADDR_WIDTH) == 32'd0);
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      shift_q       <= '0;
      last_load_q   <= 1'b1;
      o_Fetch_Ack   <= 1'b0;
      o_Fetch_Err   <= 1'b0;
      o_Instruction <= '0;
      o_Load_Ack    <= 1'b0;
      o_Mem_We      <= 1'b0;
      o_Mem_Addr    <= '0;
      o_Mem_Wdata   <= '0;
    end else begin
      o_Fetch_Ack <= 1'b0;
      o_Fetch_Err <= 1'b0;
      o_Load_Ack  <= 1'b0;
      o_Mem_We    <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (grant_fetch) begin
            last_load_q <= 1'b0;
            if (fetch_legal) begin
              state_q    <= StFetch;
              cnt_q      <= '0;
              o_Mem_Addr <= i_Fetch_Addr[ADDR_WIDTH-1:0];
            end else begin
              o_Fetch_Ack   <= 1'b1;
              o_Fetch_Err   <= 1'b1;
              o_Instruction <= 32'h0000_0013;
            end
          end else if (grant_load) begin
            last_load_q <= 1'b1;
            o_Load_Ack  <= 1'b1;
            if (load_in_range) begin
              state_q     <= StLoad;
              o_Mem_We    <= 1'b1;
              o_Mem_Addr  <= i_Load_Addr[ADDR_WIDTH-1:0];
              o_Mem_Wdata <= i_Load_Data;
            end
          end
        end
        StFetch: begin
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q < 3'd3) begin
            o_Mem_Addr <= o_Mem_Addr + ADDR_WIDTH'(1);
          end
          // Read data lags the address by one cycle, so byte lane k arrives at cnt == k+1.
          if (cnt_q != 3'd0) begin
            shift_q <= {i_Mem_Rdata, shift_q[23:8]};
          end
          if (cnt_q == 3'd4) begin
            o_Instruction <= {i_Mem_Rdata, shift_q};
            o_Fetch_Ack   <= 1'b1;
            state_q       <= StIdle;
          end
        end
        StLoad: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: doc/imem_port_arbiter.md
# imem_port_arbiter

Sequencer and two-way arbiter for the byte-wide, single-port instruction memory. It lets the core fetch stage read 32-bit little-endian instructions through four byte beats. A program loader can write the same memory byte by byte through a second port. It sits between the fetch stage / loader and the memory macro, and owns every memory address, write-enable and write-data cycle.

## Interface
- ADDR_WIDTH, 8, byte-address width of the memory (depth 2^ADDR_WIDTH bytes; 8 gives 256 bytes).
- i_Clk  in  1  system clock; every register updates on the rising edge.
- i_Rst_n  in  1  reset, synchronous and active-low.
- i_Fetch_Req  in  1  fetch request; held high, with the address stable, until o_Fetch_Ack.
- i_Fetch_Addr  in  32  byte address of the instruction.
- o_Fetch_Ack  out  1  one-cycle pulse; o_Instruction and o_Fetch_Err are valid in this cycle.
- o_Instruction  out  32  {byte[A+3], byte[A+2], byte[A+1], byte[A]}; holds its value until the next ack.
- o_Fetch_Err  out  1  pulses with o_Fetch_Ack when the fetch address is illegal.
- i_Load_Req  in  1  loader byte-write request; held high until o_Load_Ack.
- i_Load_Addr  in  32  byte address to write.
- i_Load_Data  in  8  byte to write.
- o_Load_Ack  out  1  one-cycle pulse when the write is done, or dropped as out of range.
- o_Mem_Addr  out  ADDR_WIDTH  memory byte address.
- o_Mem_Wdata  out  8  memory write data.
- o_Mem_We  out  1  memory write enable.
- i_Mem_Rdata  in  8  memory read data; synchronous, valid one cycle after o_Mem_Addr.

## Operation
- All outputs are registered.
- States:
  - IDLE: no memory access in progress.
  - FETCH: 3-bit beat counter `cnt`, 0..4.
  - LOAD: one-cycle byte write.
- IDLE arbitration:
  - If only one request is high, grant it.
  - If both are high, grant the port not granted last (`last_grant` flag). Reset sets `last_grant` = loader, so the fetch port wins the first contention.
  - A granted transaction always runs to completion; there is no preemption.
- A fetch address is legal when i_Fetch_Addr[1:0] == 0 and i_Fetch_Addr[31:ADDR_WIDTH] == 0.
- Illegal fetch:
  - Stay in IDLE; no memory cycle is issued.
  - At the next edge pulse o_Fetch_Ack and o_Fetch_Err, and set o_Instruction = 32'h00000013 (NOP).
- Legal fetch:
  - Latch the base address A and enter FETCH with cnt = 0.
  - While cnt < 4: o_Mem_Addr = A + cnt, o_Mem_We = 0.
  - While cnt >= 1: capture i_Mem_Rdata into instruction byte lane cnt-1.
  - cnt increments every cycle. At cnt == 4 the last byte is captured, o_Fetch_Ack pulses, and the state returns to IDLE.
- Load:
  - If i_Load_Addr[31:ADDR_WIDTH] != 0, ack at the next edge with no write.
  - Otherwise enter LOAD. For one cycle drive o_Mem_We = 1, o_Mem_Addr = i_Load_Addr[ADDR_WIDTH-1:0] and o_Mem_Wdata = i_Load_Data, with o_Load_Ack pulsing in the same cycle. Then return to IDLE.
- Address arithmetic is ADDR_WIDTH bits wide. No wrap-around can occur, because legal fetches are word-aligned and in range.
- A request still high in the cycle after its ack counts as a new request and re-enters arbitration.
- `last_grant` updates on every grant, including error acks.
- Reset (i_Rst_n low at an edge) in any state:
  - Aborts the transaction and goes to IDLE.
  - Clears o_Fetch_Ack, o_Fetch_Err, o_Instruction, o_Load_Ack, o_Mem_We, o_Mem_Addr and o_Mem_Wdata to 0.
  - Sets `last_grant` = loader.
  - A write in flight is de-asserted at that edge.

## Timing
- Legal fetch:
  - Accepted at edge E0; o_Mem_Addr = A+0..A+3 during cycles E0..E3.
  - Bytes are captured at E2..E5.
  - o_Fetch_Ack is high in the cycle after E5 (5 cycles from acceptance).
  - Minimum issue interval is 6 cycles per instruction, including the IDLE cycle.
- Error ack: high in the cycle after the accepting edge (1 cycle).
- Load:
  - Accepted at E0; o_Mem_We and o_Load_Ack are high in the cycle after E0.
  - Back in IDLE at E1; throughput is 1 byte per 2 cycles.
- o_Mem_We is never high in IDLE or FETCH.
- At most one ack is high in any cycle.

## Test plan
- Memory bytes 0x10..0x13 = 93,00,50,00; fetch at 0x10 -> ack 5 cycles after acceptance, o_Instruction = 0x00500093, o_Fetch_Err = 0, o_Mem_We never high.
- Loader writes 0x13,0x05,0x10,0x00 to 0x20..0x23, then fetch at 0x20 -> four acks with a single o_Mem_We cycle each at the correct address/data; fetch returns 0x00100513.
- Fetch at 0x22, and separately at 0x100 (ADDR_WIDTH = 8) -> ack + err one cycle after the request, o_Instruction = 0x00000013, no memory address change.
- Both requests high from reset and held -> grant order fetch, load, fetch, load; each transaction runs to completion; acks never overlap.
- Assert i_Rst_n = 0 at cnt == 2 of a fetch, and separately during a LOAD cycle -> all outputs 0 at that edge, no ack, o_Mem_We low; after release, a pending fetch wins against the loader.
- Sweep 64 consecutive word fetches from 0x00 against a byte-preloaded 256-byte model -> every o_Instruction equals {m[A+3], m[A+2], m[A+1], m[A]}.
